rr_arbiter3: RTL

RR_ARBITER3 -- requirements
Module: rr_arbiter3

---
 rtl/rr_arbiter3.sv | 110 +++++++++++
 1 files changed

// File: rtl/rr_arbiter3.sv
// Three-way round-robin arbiter. Each grant is held until the owner reports done,
// the owner drops its request, or the hold limit is reached.
//
// state   | meaning
// IDLE    | nobody owns the resource; requests are evaluated every edge
// GRANT   | one requester owns the resource; the hold counter runs
// RELEASE | one-cycle gap after a grant; timeout pulses here if forced
module rr_arbiter3 #(
   parameter int unsigned MAX_HOLD = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [2:0] req,
   input  logic       done,
   output logic [2:0] gnt,
   output logic [1:0] gnt_id,
   output logic       busy,
   output logic       timeout
);

   typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

   localparam logic [3:0] MAX_CNT = 4'(MAX_HOLD);

   state_t     state;
   logic [1:0] last;
   logic [1:0] owner;
   logic [3:0] cnt;

   logic [1:0] s0, s1, s2;
   logic [1:0] pick;
   logic       owner_req;
   logic       hold_hit;
   logic       exit_grant;

   // Search order starts one past the previous owner and wraps 2 -> 0.
   always_comb begin
      s0 = 2'd0;
      s1 = 2'd1;
      s2 = 2'd2;
      case (last)
         2'd0: begin s0 = 2'd1; s1 = 2'd2; s2 = 2'd0; end
         2'd1: begin s0 = 2'd2; s1 = 2'd0; s2 = 2'd1; end
         default: begin s0 = 2'd0; s1 = 2'd1; s2 = 2'd2; end
      endcase
      pick = s2;
      if (req[s0])
         pick = s0;
      else if (req[s1])
         pick = s1;
   end

   assign owner_req  = req[owner];
   assign hold_hit   = (cnt == MAX_CNT);
   assign exit_grant = done || !owner_req || hold_hit;

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         gnt     <= 3'b000;
         gnt_id  <= 2'b11;
         busy    <= 1'b0;
         timeout <= 1'b0;
         cnt     <= 4'd0;
         last    <= 2'd2;
         owner   <= 2'd0;
      end else begin
         case (state)
            IDLE: begin
               timeout <= 1'b0;
               if (|req) begin
                  state  <= GRANT;
                  owner  <= pick;
                  gnt    <= 3'b001 << pick;
                  gnt_id <= pick;
                  busy   <= 1'b1;
                  cnt    <= 4'd1;
               end
            end
            GRANT: begin
               if (exit_grant) begin
                  state   <= RELEASE;
                  gnt     <= 3'b000;
                  gnt_id  <= 2'b11;
                  busy    <= 1'b0;
                  // Forced release only when the limit alone ended the grant.
                  timeout <= hold_hit && !done && owner_req;
                  last    <= owner;
                  cnt     <= 4'd0;
               end else begin
                  cnt <= cnt + 4'd1;
               end
            end
            RELEASE: begin
               state   <= IDLE;
               timeout <= 1'b0;
            end
            default: begin
               state   <= IDLE;
               gnt     <= 3'b000;
               gnt_id  <= 2'b11;
               busy    <= 1'b0;
               timeout <= 1'b0;
               cnt     <= 4'd0;
            end
         endcase
      end
   end

endmodule
